regfile_wr_arbiter: RTL and testbench

- Owns the register file's single write port and shares it between two writeback requesters: A (ALU/execute) and B (memory/load).
- Drives the 4-bit write register index that feeds the register file's 4-to-16 write-select decoder, plus the write enable and data.
- After reset, runs an init sweep that writes zero to every register before accepting requests.
- Each requester gets a one-entry holding buffer with valid/ready handshake; round-robin arbitration, with same-register ordering preserved.

---
 rtl/regfile_wr_arbiter_pkg.sv | 24 ++
 rtl/regfile_wr_arbiter_wr_hold_buf.sv | 43 ++++
 rtl/regfile_wr_arbiter.sv | 163 ++++++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package regfile_wr_arbiter_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 4;

   // INIT sweeps every register to zero; RUN serves the two requesters.
   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Requester ids, also used as the encoding of the age flag and rr pointer.
   localparam logic REQ_A = 1'b0;
   localparam logic REQ_B = 1'b1;

   // Register-file write port bundle at the default widths.
   typedef struct packed {
      logic                  en;
      logic [ADDR_W_DEF-1:0] idx;
      logic [DATA_W_DEF-1:0] data;
   } wr_port_t;

endpackage

// File: rtl/regfile_wr_arbiter_wr_hold_buf.sv
// One-entry holding buffer for a single writeback requester.
// A load and a drain on the same edge keep the buffer full with the new entry.
module wr_hold_buf #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_load,
   input  logic              i_drain,
   input  logic [ADDR_W-1:0] i_reg,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_full,
   output logic [ADDR_W-1:0] o_reg,
   output logic [DATA_W-1:0] o_data
);

   logic              r_full;
   logic [ADDR_W-1:0] r_reg;
   logic [DATA_W-1:0] r_data;

   // Capture a new entry on load, otherwise empty the slot when drained.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_full <= 1'b0;
         r_reg  <= '0;
         r_data <= '0;
      end else begin
         if (i_load) begin
            r_full <= 1'b1;
            r_reg  <= i_reg;
            r_data <= i_data;
         end else if (i_drain) begin
            r_full <= 1'b0;
         end
      end
   end

   assign o_full = r_full;
   assign o_reg  = r_reg;
   assign o_data = r_data;

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter: zero-initialises every register after
// reset, then shares the single write port between requester A (execute)
// and requester B (load) with round-robin fairness and same-register order.
//
// Handshake: a transfer happens on x_valid & x_ready at a rising clk edge;
// the requester holds valid/reg/data stable until it sees ready, and ready
// never depends on valid (x_ready = RUN & (buffer empty | buffer granted)).
module regfile_wr_arbiter
   import regfile_wr_arbiter_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              a_valid,
   output logic              a_ready,
   input  logic [ADDR_W-1:0] a_reg,
   input  logic [DATA_W-1:0] a_data,
   input  logic              b_valid,
   output logic              b_ready,
   input  logic [ADDR_W-1:0] b_reg,
   input  logic [DATA_W-1:0] b_data,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_reg,
   output logic [DATA_W-1:0] wr_data,
   output logic              init_done
);

   localparam int                NREG     = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NREG - 1);

   state_t            r_state;
   logic [ADDR_W-1:0] r_init_cnt;
   logic              r_init_done;
   logic              r_age;   // side holding the older entry
   logic              r_rr;    // side favoured on the next contended grant

   logic              w_run;
   logic              w_a_full, w_b_full;
   logic [ADDR_W-1:0] w_a_reg, w_b_reg;
   logic [DATA_W-1:0] w_a_data, w_b_data;
   logic              w_both, w_same;
   logic              w_pick;
   logic              w_grant_a, w_grant_b;
   logic              w_load_a, w_load_b;
   logic              w_zero_a, w_zero_b;

   assign w_run = (r_state == ST_RUN);

   wr_hold_buf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_buf_a (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_load_a),
      .i_drain (w_grant_a),
      .i_reg   (a_reg),
      .i_data  (a_data),
      .o_full  (w_a_full),
      .o_reg   (w_a_reg),
      .o_data  (w_a_data)
   );

   wr_hold_buf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_buf_b (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_load_b),
      .i_drain (w_grant_b),
      .i_reg   (b_reg),
      .i_data  (b_data),
      .o_full  (w_b_full),
      .o_reg   (w_b_reg),
      .o_data  (w_b_data)
   );

   assign w_both = w_a_full & w_b_full;
   assign w_same = (w_a_reg == w_b_reg);

   // Choose a side among full buffers: age wins on a register clash, else rr.
   always_comb begin
      w_pick = REQ_A;
      if (w_both) begin
         w_pick = w_same ? r_age : r_rr;
      end else if (w_b_full) begin
         w_pick = REQ_B;
      end
   end

   assign w_grant_a = w_run & w_a_full & (w_pick == REQ_A);
   assign w_grant_b = w_run & w_b_full & (w_pick == REQ_B);

   assign a_ready  = w_run & (~w_a_full | w_grant_a);
   assign b_ready  = w_run & (~w_b_full | w_grant_b);
   assign w_load_a = a_valid & a_ready;
   assign w_load_b = b_valid & b_ready;

   // Writes to a hardwired-zero register 0 are consumed without a port write.
   assign w_zero_a = (ZERO_REG != 0) && (w_a_reg == '0);
   assign w_zero_b = (ZERO_REG != 0) && (w_b_reg == '0);

   // Drive the write port from the init sweep or from the granted buffer.
   always_comb begin
      wr_en   = 1'b0;
      wr_reg  = '0;
      wr_data = '0;
      if (r_state == ST_INIT) begin
         wr_en  = 1'b1;
         wr_reg = r_init_cnt;
      end else if (w_grant_a) begin
         wr_en   = ~w_zero_a;
         wr_reg  = w_a_reg;
         wr_data = w_a_data;
      end else if (w_grant_b) begin
         wr_en   = ~w_zero_b;
         wr_reg  = w_b_reg;
         wr_data = w_b_data;
      end
   end

   // Init sweep FSM: count through every register once, then serve requests.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_INIT;
         r_init_cnt  <= '0;
         r_init_done <= 1'b0;
      end else begin
         case (r_state)
            ST_INIT: begin
               r_init_cnt <= r_init_cnt + 1'b1;
               if (r_init_cnt == LAST_REG) begin
                  r_state     <= ST_RUN;
                  r_init_done <= 1'b1;
               end
            end
            default: begin
               r_state <= ST_RUN;
            end
         endcase
      end
   end

   // Track which buffer is older and rotate the pointer after contended grants.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_age <= REQ_A;
         r_rr  <= REQ_A;
      end else begin
         if (w_load_a & w_load_b) begin
            r_age <= REQ_A;
         end else if (w_load_a & w_b_full & ~w_grant_b) begin
            r_age <= REQ_B;
         end else if (w_load_b & w_a_full & ~w_grant_a) begin
            r_age <= REQ_A;
         end
         if (w_both & (w_grant_a | w_grant_b)) begin
            r_rr <= w_grant_a ? REQ_B : REQ_A;
         end
      end
   end

   assign init_done = r_init_done;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: init sweep, streaming, contention,
// same-register ordering, R0 discard and mid-operation reset.
module tb_regfile_wr_arbiter;

   localparam int DW   = 16;
   localparam int AW   = 4;
   localparam int NREG = 16;

   // ---------------- clock / reset / DUT ----------------
   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          a_valid, a_ready, b_valid, b_ready;
   logic [AW-1:0] a_reg, b_reg, wr_reg;
   logic [DW-1:0] a_data, b_data, wr_data;
   logic          wr_en, init_done;

   always #5 clk = ~clk;

   regfile_wr_arbiter #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut (
      .clk       (clk),
      .rst       (rst),
      .a_valid   (a_valid),
      .a_ready   (a_ready),
      .a_reg     (a_reg),
      .a_data    (a_data),
      .b_valid   (b_valid),
      .b_ready   (b_ready),
      .b_reg     (b_reg),
      .b_data    (b_data),
      .wr_en     (wr_en),
      .wr_reg    (wr_reg),
      .wr_data   (wr_data),
      .init_done (init_done)
   );

   // ---------------- bookkeeping ----------------
   int total = 0;
   int bad   = 0;
   logic [AW+DW-1:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic          av;
      logic [AW-1:0] ar;
      logic [DW-1:0] ad;
      logic          bv;
      logic [AW-1:0] br;
      logic [DW-1:0] bd;
      logic          ea;
      logic          eb;
      logic          een;
      logic [AW-1:0] ereg;
      logic [DW-1:0] edata;
   } vec_t;

   vec_t vec[$];

   function automatic vec_t mk(input logic av, input logic [AW-1:0] ar, input logic [DW-1:0] ad,
                               input logic bv, input logic [AW-1:0] br, input logic [DW-1:0] bd,
                               input logic ea, input logic eb, input logic een,
                               input logic [AW-1:0] ereg, input logic [DW-1:0] edata);
      vec_t v;
      v.av = av; v.ar = ar; v.ad = ad;
      v.bv = bv; v.br = br; v.bd = bd;
      v.ea = ea; v.eb = eb; v.een = een; v.ereg = ereg; v.edata = edata;
      return v;
   endfunction

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (!rst && init_done && wr_en) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_unexpected: got write reg %0d data %h, required no write", wr_reg, wr_data);
         end else begin
            check("sb_write", {12'h0, wr_reg, wr_data}, {12'h0, exp_q.pop_front()});
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic idle_inputs();
      a_valid = 1'b0; a_reg = '0; a_data = '0;
      b_valid = 1'b0; b_reg = '0; b_data = '0;
   endtask

   // Release reset and check the whole zeroing sweep plus the init_done rise.
   task automatic release_and_sweep(input string tag);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < NREG; i++) begin
         @(negedge clk);
         check($sformatf("%s_init[%0d]", tag, i),
               {8'h0, wr_en, wr_reg, wr_data, a_ready, b_ready, init_done},
               {8'h0, 1'b1, 4'(i), 16'h0000, 3'b000});
      end
      @(negedge clk);
      check($sformatf("%s_init_done", tag),
            {28'h0, init_done, wr_en, a_ready, b_ready}, {28'h0, 4'b1011});
   endtask

   task automatic do_reset(input string tag);
      @(posedge clk);
      #1 rst = 1'b1;
      idle_inputs();
      release_and_sweep(tag);
   endtask

   task automatic run_table(input string name);
      logic [31:0] act, exp;
      for (int i = 0; i < vec.size(); i++) begin
         @(posedge clk);
         #1;
         a_valid = vec[i].av; a_reg = vec[i].ar; a_data = vec[i].ad;
         b_valid = vec[i].bv; b_reg = vec[i].br; b_data = vec[i].bd;
         if (vec[i].een) exp_q.push_back({vec[i].ereg, vec[i].edata});
         @(negedge clk);
         act = {9'h0, a_ready, b_ready, wr_en,
                (vec[i].een ? wr_reg : 4'h0), (vec[i].een ? wr_data : 16'h0)};
         exp = {9'h0, vec[i].ea, vec[i].eb, vec[i].een, vec[i].ereg, vec[i].edata};
         check($sformatf("%s[%0d]", name, i), act, exp);
      end
      idle_inputs();
      vec.delete();
   endtask

   // ---------------- test sequence ----------------
   initial begin
      idle_inputs();
      rst = 1'b1;

      // Init sweep after the first reset.
      release_and_sweep("por");

      // Single requester streaming: one write per cycle, one cycle after accept.
      vec.push_back(mk(1, 3, 16'h1111, 0, 0, 0, 1, 1, 0, 0, 0));
      vec.push_back(mk(1, 4, 16'h2222, 0, 0, 0, 1, 1, 1, 3, 16'h1111));
      vec.push_back(mk(1, 5, 16'h3333, 0, 0, 0, 1, 1, 1, 4, 16'h2222));
      vec.push_back(mk(0, 0, 0,        0, 0, 0, 1, 1, 1, 5, 16'h3333));
      vec.push_back(mk(0, 0, 0,        0, 0, 0, 1, 1, 0, 0, 0));
      run_table("stream");

      // Contention on different registers: alternate A,B,A,B from rr=A.
      do_reset("r1");
      vec.push_back(mk(1, 1, 16'hA001, 1, 8,  16'hB008, 1, 1, 0, 0,  0));
      vec.push_back(mk(1, 2, 16'hA002, 1, 9,  16'hB009, 1, 0, 1, 1,  16'hA001));
      vec.push_back(mk(1, 3, 16'hA003, 1, 9,  16'hB009, 0, 1, 1, 8,  16'hB008));
      vec.push_back(mk(1, 3, 16'hA003, 1, 10, 16'hB00A, 1, 0, 1, 2,  16'hA002));
      vec.push_back(mk(0, 0, 0,        1, 10, 16'hB00A, 0, 1, 1, 9,  16'hB009));
      vec.push_back(mk(0, 0, 0,        0, 0,  0,        1, 0, 1, 3,  16'hA003));
      vec.push_back(mk(0, 0, 0,        0, 0,  0,        1, 1, 1, 10, 16'hB00A));
      vec.push_back(mk(0, 0, 0,        0, 0,  0,        1, 1, 0, 0,  0));
      run_table("contend");

      // Same register: B loaded an edge before A while the port is busy.
      do_reset("r2");
      vec.push_back(mk(1, 1, 16'h0101, 1, 6, 16'hBBBB, 1, 1, 0, 0, 0));
      vec.push_back(mk(1, 6, 16'hAAAA, 0, 0, 0,        1, 0, 1, 1, 16'h0101));
      vec.push_back(mk(0, 0, 0,        0, 0, 0,        0, 1, 1, 6, 16'hBBBB));
      vec.push_back(mk(0, 0, 0,        0, 0, 0,        1, 1, 1, 6, 16'hAAAA));
      vec.push_back(mk(0, 0, 0,        0, 0, 0,        1, 1, 0, 0, 0));
      run_table("same_reg");

      // Same register loaded on one edge while rr points at B: A still first.
      do_reset("r3");
      vec.push_back(mk(1, 1, 16'h0111, 1, 8, 16'h0888, 1, 1, 0, 0, 0));
      vec.push_back(mk(0, 0, 0,        0, 0, 0,        1, 0, 1, 1, 16'h0111));
      vec.push_back(mk(0, 0, 0,        0, 0, 0,        1, 1, 1, 8, 16'h0888));
      vec.push_back(mk(1, 7, 16'hA7A7, 1, 7, 16'hB7B7, 1, 1, 0, 0, 0));
      vec.push_back(mk(0, 0, 0,        0, 0, 0,        1, 0, 1, 7, 16'hA7A7));
      vec.push_back(mk(0, 0, 0,        0, 0, 0,        1, 1, 1, 7, 16'hB7B7));
      vec.push_back(mk(0, 0, 0,        0, 0, 0,        1, 1, 0, 0, 0));
      run_table("age_vs_rr");

      // Register 0 write is consumed silently; the next one issues right after.
      do_reset("r4");
      vec.push_back(mk(1, 0, 16'hFFFF, 0, 0, 0, 1, 1, 0, 0, 0));
      vec.push_back(mk(1, 7, 16'h7777, 0, 0, 0, 1, 1, 0, 0, 0));
      vec.push_back(mk(0, 0, 0,        0, 0, 0, 1, 1, 1, 7, 16'h7777));
      vec.push_back(mk(0, 0, 0,        0, 0, 0, 1, 1, 0, 0, 0));
      run_table("r0_discard");

      // Reset mid-operation with both buffers full.
      do_reset("r5");
      @(posedge clk);
      #1;
      a_valid = 1'b1; a_reg = 4'd2; a_data = 16'h2222;
      b_valid = 1'b1; b_reg = 4'd3; b_data = 16'h3333;
      @(negedge clk);
      check("mid_fill_ready", {30'h0, a_ready, b_ready}, {30'h0, 2'b11});
      @(posedge clk);
      #1 idle_inputs();
      check("mid_both_full", {25'h0, a_ready, b_ready, wr_en, wr_reg}, {25'h0, 3'b101, 4'd2});
      #2 rst = 1'b1;
      #1;
      check("mid_rst_drop", {9'h0, a_ready, b_ready, init_done, wr_reg, wr_data},
            {9'h0, 3'b000, 4'd0, 16'h0000});
      release_and_sweep("mid");
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check($sformatf("mid_no_stale[%0d]", i), {31'h0, wr_en}, 32'h0);
      end

      check("sb_drained", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
